ccff_loader: RTL and testbench

CCFF_LOADER -- requirements
Module: ccff_loader

---
 rtl/ccff_pkg.sv | 14 +
 rtl/ccff_sig_accum.sv | 38 +++
 rtl/ccff_loader.sv | 106 ++++++++++
 tb/tb_ccff_loader.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// Shared configuration for the configuration-chain loader.
// Holds the FSM state encoding and the default chain count.
package ccff_pkg;

   localparam int NUM_CHAINS_DEF = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_e;

endpackage

// File: rtl/ccff_sig_accum.sv
// Per-chain XOR signature of the fabric chain tails.
// A clear beats an update in the same cycle.
module ccff_sig_accum
   import ccff_pkg::*;
#(
   parameter int W = NUM_CHAINS_DEF
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] tail_i,
   output logic [W-1:0] sig_o
);

   logic [W-1:0] sig_q;
   logic [W-1:0] sig_d;

   always_comb begin
      sig_d = sig_q;
      if (clr_i) begin
         sig_d = '0;
      end else if (en_i) begin
         sig_d = sig_q ^ tail_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig_o = sig_q;

endmodule

// File: rtl/ccff_loader.sv
// Streams a bitstream into NUM_CHAINS parallel configuration chains,
// checks the load length and signs the chain tails.
module ccff_loader
   import ccff_pkg::*;
#(
   parameter int NUM_CHAINS = NUM_CHAINS_DEF,
   parameter int CHAIN_LEN  = 4096,
   parameter int CNT_W      = 13
) (
   input  logic                  prog_clock,
   input  logic                  prog_reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  bs_valid,
   output logic                  bs_ready,
   input  logic [NUM_CHAINS-1:0] bs_data,
   input  logic                  bs_last,
   output logic [NUM_CHAINS-1:0] ccff_head,
   input  logic [NUM_CHAINS-1:0] ccff_tail,
   output logic                  ccff_shift_en,
   output logic [CNT_W-1:0]      shift_count,
   output logic [NUM_CHAINS-1:0] tail_sig,
   output logic                  cfg_done,
   output logic                  cfg_error
);

   state_e                  state_q;
   logic [NUM_CHAINS-1:0]   head_q;
   logic                    shift_en_q;
   logic [CNT_W-1:0]        count_q;
   logic                    done_q;
   logic                    error_q;

   logic                    accept;
   logic                    last_word;
   logic                    sig_clr;

   assign bs_ready  = (state_q == LOAD);
   assign accept    = bs_valid & bs_ready & ~abort;
   assign last_word = (count_q == CNT_W'(CHAIN_LEN - 1));
   assign sig_clr   = start & ~abort & (state_q != LOAD);

   always_ff @(posedge prog_clock or posedge prog_reset) begin
      if (prog_reset) begin
         state_q    <= IDLE;
         head_q     <= '0;
         shift_en_q <= 1'b0;
         count_q    <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         shift_en_q <= 1'b0;
         if (abort) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE, DONE, ERR: begin
                  if (start) begin
                     state_q <= LOAD;
                     count_q <= '0;
                     done_q  <= 1'b0;
                     error_q <= 1'b0;
                  end
               end
               LOAD: begin
                  if (accept) begin
                     head_q     <= bs_data;
                     shift_en_q <= 1'b1;
                     count_q    <= count_q + CNT_W'(1);
                     // Length must end exactly on the last word of the chain
                     if (last_word && bs_last) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end else if (last_word || bs_last) begin
                        state_q <= ERR;
                        error_q <= 1'b1;
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   ccff_sig_accum #(
      .W (NUM_CHAINS)
   ) u_sig (
      .clk_i  (prog_clock),
      .rst_i  (prog_reset),
      .clr_i  (sig_clr),
      .en_i   (shift_en_q),
      .tail_i (ccff_tail),
      .sig_o  (tail_sig)
   );

   assign ccff_head     = head_q;
   assign ccff_shift_en = shift_en_q;
   assign shift_count   = count_q;
   assign cfg_done      = done_q;
   assign cfg_error     = error_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader with four-word chains.
// Each task drives one scenario and checks its own expectations.
module tb_ccff_loader;

   localparam int NC  = 10;
   localparam int CL  = 4;
   localparam int CW  = 13;

   logic          clk;
   logic          rst;
   logic          start;
   logic          abort;
   logic          bs_valid;
   logic          bs_ready;
   logic [NC-1:0] bs_data;
   logic          bs_last;
   logic [NC-1:0] ccff_head;
   logic [NC-1:0] ccff_tail;
   logic          ccff_shift_en;
   logic [CW-1:0] shift_count;
   logic [NC-1:0] tail_sig;
   logic          cfg_done;
   logic          cfg_error;

   int total;
   int bad;
   int pulse_total;
   int base;

   ccff_loader #(
      .NUM_CHAINS (NC),
      .CHAIN_LEN  (CL),
      .CNT_W      (CW)
   ) dut (
      .prog_clock    (clk),
      .prog_reset    (rst),
      .start         (start),
      .abort         (abort),
      .bs_valid      (bs_valid),
      .bs_ready      (bs_ready),
      .bs_data       (bs_data),
      .bs_last       (bs_last),
      .ccff_head     (ccff_head),
      .ccff_tail     (ccff_tail),
      .ccff_shift_en (ccff_shift_en),
      .shift_count   (shift_count),
      .tail_sig      (tail_sig),
      .cfg_done      (cfg_done),
      .cfg_error     (cfg_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial pulse_total = 0;
   always @(posedge clk) begin
      if (ccff_shift_en === 1'b1) pulse_total++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_word(input logic [NC-1:0] d, input logic last,
                            input logic [NC-1:0] tl);
      bs_valid = 1'b1;
      bs_data  = d;
      bs_last  = last;
      tick();
      bs_valid  = 1'b0;
      bs_last   = 1'b0;
      ccff_tail = tl;
      total++;
      if (ccff_shift_en !== 1'b1) begin
         bad++;
         $display("FAIL word_shift: got %b want 1 (data %h)", ccff_shift_en, d);
      end
      total++;
      if (ccff_head !== d) begin
         bad++;
         $display("FAIL word_head: got %h want %h", ccff_head, d);
      end
   endtask

   task automatic check_all_zero(input string nm);
      total++;
      if ({ccff_head, ccff_shift_en, bs_ready, shift_count,
           tail_sig, cfg_done, cfg_error} !== '0) begin
         bad++;
         $display("FAIL %s: head=%h sh=%b rdy=%b cnt=%0d sig=%h dn=%b er=%b want all 0",
                  nm, ccff_head, ccff_shift_en, bs_ready, shift_count,
                  tail_sig, cfg_done, cfg_error);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      check_all_zero("reset_async");
      #12;
      check_all_zero("reset_held");
      rst = 1'b0;
      tick();
      check_all_zero("after_reset");
   endtask

   task automatic test_normal();
      do_start();
      total++;
      if (bs_ready !== 1'b1) begin
         bad++;
         $display("FAIL normal_ready: got %b want 1", bs_ready);
      end
      base = pulse_total;
      send_word(10'h001, 1'b0, 10'h155);
      send_word(10'h002, 1'b0, 10'h155);
      send_word(10'h004, 1'b0, 10'h155);
      send_word(10'h3FF, 1'b1, 10'h155);
      total++;
      if ({cfg_done, cfg_error, bs_ready} !== 3'b100) begin
         bad++;
         $display("FAIL normal_done: got dn/er/rdy=%b want 100",
                  {cfg_done, cfg_error, bs_ready});
      end
      total++;
      if (shift_count !== CW'(4)) begin
         bad++;
         $display("FAIL normal_count: got %0d want 4", shift_count);
      end
      tick();
      total++;
      if (ccff_shift_en !== 1'b0) begin
         bad++;
         $display("FAIL normal_shift_off: got %b want 0", ccff_shift_en);
      end
      total++;
      if (pulse_total - base !== 4) begin
         bad++;
         $display("FAIL normal_pulses: got %0d want 4", pulse_total - base);
      end
      total++;
      if (tail_sig !== 10'h000) begin
         bad++;
         $display("FAIL normal_sig_even: got %h want 000", tail_sig);
      end
   endtask

   task automatic test_stall();
      do_start();
      total++;
      if (tail_sig !== 10'h000 || shift_count !== CW'(0)) begin
         bad++;
         $display("FAIL stall_clear: got sig=%h cnt=%0d want 000/0",
                  tail_sig, shift_count);
      end
      base = pulse_total;
      send_word(10'h001, 1'b0, 10'h001);
      send_word(10'h002, 1'b0, 10'h010);
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         start = 1'b0;
         total++;
         if (ccff_shift_en !== 1'b0 || ccff_head !== 10'h002) begin
            bad++;
            $display("FAIL stall_hold%0d: got sh=%b head=%h want 0/002",
                     i, ccff_shift_en, ccff_head);
         end
      end
      total++;
      if (shift_count !== CW'(2) || bs_ready !== 1'b1) begin
         bad++;
         $display("FAIL stall_start_ignored: got cnt=%0d rdy=%b want 2/1",
                  shift_count, bs_ready);
      end
      send_word(10'h004, 1'b0, 10'h100);
      send_word(10'h3FF, 1'b1, 10'h003);
      tick();
      total++;
      if (cfg_done !== 1'b1 || pulse_total - base !== 4) begin
         bad++;
         $display("FAIL stall_done: got dn=%b pulses=%0d want 1/4",
                  cfg_done, pulse_total - base);
      end
      total++;
      if (tail_sig !== 10'h112) begin
         bad++;
         $display("FAIL stall_sig: got %h want 112", tail_sig);
      end
   endtask

   task automatic test_early_last();
      do_start();
      send_word(10'h0AA, 1'b0, 10'h000);
      send_word(10'h055, 1'b1, 10'h000);
      total++;
      if ({cfg_error, cfg_done, bs_ready} !== 3'b100) begin
         bad++;
         $display("FAIL early_err: got er/dn/rdy=%b want 100",
                  {cfg_error, cfg_done, bs_ready});
      end
      total++;
      if (shift_count !== CW'(2)) begin
         bad++;
         $display("FAIL early_count: got %0d want 2", shift_count);
      end
   endtask

   task automatic test_no_last();
      do_start();
      base = pulse_total;
      send_word(10'h101, 1'b0, 10'h000);
      send_word(10'h202, 1'b0, 10'h000);
      send_word(10'h303, 1'b0, 10'h000);
      total++;
      if (cfg_error !== 1'b0 || bs_ready !== 1'b1) begin
         bad++;
         $display("FAIL nolast_early: got er=%b rdy=%b want 0/1",
                  cfg_error, bs_ready);
      end
      send_word(10'h004, 1'b0, 10'h000);
      tick();
      total++;
      if (cfg_error !== 1'b1 || cfg_done !== 1'b0 || pulse_total - base !== 4) begin
         bad++;
         $display("FAIL nolast_err: got er=%b dn=%b pulses=%0d want 1/0/4",
                  cfg_error, cfg_done, pulse_total - base);
      end
   endtask

   task automatic test_tail_odd();
      do_start();
      send_word(10'h011, 1'b0, 10'h155);
      send_word(10'h022, 1'b0, 10'h155);
      send_word(10'h033, 1'b1, 10'h155);
      tick();
      total++;
      if (cfg_error !== 1'b1 || shift_count !== CW'(3)) begin
         bad++;
         $display("FAIL odd_err: got er=%b cnt=%0d want 1/3", cfg_error, shift_count);
      end
      total++;
      if (tail_sig !== 10'h155) begin
         bad++;
         $display("FAIL odd_sig: got %h want 155", tail_sig);
      end
   endtask

   task automatic test_abort();
      do_start();
      send_word(10'h0F0, 1'b0, 10'h200);
      send_word(10'h00F, 1'b0, 10'h0C0);
      abort    = 1'b1;
      bs_valid = 1'b1;
      bs_data  = 10'h3CC;
      tick();
      abort    = 1'b0;
      bs_valid = 1'b0;
      total++;
      if (ccff_shift_en !== 1'b0 || ccff_head !== 10'h00F) begin
         bad++;
         $display("FAIL abort_discard: got sh=%b head=%h want 0/00F",
                  ccff_shift_en, ccff_head);
      end
      total++;
      if ({shift_count, bs_ready, cfg_done, cfg_error} !== '0) begin
         bad++;
         $display("FAIL abort_idle: got cnt=%0d rdy=%b dn=%b er=%b want 0",
                  shift_count, bs_ready, cfg_done, cfg_error);
      end
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      total++;
      if (bs_ready !== 1'b0 || ccff_shift_en !== 1'b0) begin
         bad++;
         $display("FAIL abort_wins: got rdy=%b sh=%b want 0/0",
                  bs_ready, ccff_shift_en);
      end
      do_start();
      total++;
      if (tail_sig !== 10'h000) begin
         bad++;
         $display("FAIL abort_restart_sig: got %h want 000", tail_sig);
      end
      send_word(10'h001, 1'b0, 10'h001);
      send_word(10'h002, 1'b0, 10'h002);
      send_word(10'h004, 1'b0, 10'h004);
      send_word(10'h3FF, 1'b1, 10'h008);
      tick();
      total++;
      if (cfg_done !== 1'b1 || shift_count !== CW'(4)) begin
         bad++;
         $display("FAIL abort_reload: got dn=%b cnt=%0d want 1/4",
                  cfg_done, shift_count);
      end
      total++;
      if (tail_sig !== 10'h00F) begin
         bad++;
         $display("FAIL abort_reload_sig: got %h want 00F", tail_sig);
      end
   endtask

   task automatic test_reset_mid();
      do_start();
      send_word(10'h1A5, 1'b0, 10'h3F0);
      send_word(10'h25A, 1'b0, 10'h0FF);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("reset_mid_async");
      #4;
      rst = 1'b0;
      tick();
      check_all_zero("reset_mid_after");
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst       = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      bs_valid  = 1'b0;
      bs_data   = '0;
      bs_last   = 1'b0;
      ccff_tail = '0;
      test_reset();
      test_normal();
      test_stall();
      test_early_last();
      test_no_last();
      test_tail_odd();
      test_abort();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
